// File: rtl/alu_mdu.sv
// Registered MIPS-style ALU with an iterative multiply/divide unit and HI/LO registers.
// Optional flush of an in-flight mul/div is enabled by defining ALU_MDU_FLUSH_EN.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_MDU_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Ctr,
  input  logic             alu_sign,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIN} state_t;

  state_t             r_state;
  logic [SHW-1:0]     r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;

  logic               w_flush;
  logic               w_accept;
  logic               w_is_mdu;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

`ifdef ALU_MDU_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready & ~w_flush;
  assign w_is_mdu = (ALU_Ctr[3:2] == 2'b10);

  // ALU_Ctr[0]=0 selects the signed variant (mult/div); the iteration runs on magnitudes.
  assign w_a_neg = ~ALU_Ctr[0] & A[WIDTH-1];
  assign w_b_neg = ~ALU_Ctr[0] & B[WIDTH-1];
  assign w_a_mag = w_a_neg ? -A : A;
  assign w_b_mag = w_b_neg ? -B : B;

  assign w_sum  = A + B;
  assign w_diff = A - B;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    unique case (ALU_Ctr)
      4'b0000: w_res = A & B;
      4'b0001: w_res = A | B;
      4'b0010: begin
        w_res = w_sum;
        w_ovf = alu_sign & (A[WIDTH-1] == B[WIDTH-1]) & (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0110: begin
        w_res = w_diff;
        w_ovf = alu_sign & (A[WIDTH-1] != B[WIDTH-1]) & (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0100: w_res = ~(A | B);
      4'b0011: w_res = A ^ B;
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0101: w_res = A >> B[SHW-1:0];
      4'b1100: w_res = hi;
      4'b1101: w_res = lo;
      default: w_res = '0;
    endcase
  end

  // Multiply: {r_acc, r_q} is the shifting product register, multiplier starts in r_q.
  assign w_madd = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  // Divide: r_acc is the partial remainder, dividend bits shift out of r_q top.
  assign w_shift = {r_acc, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_sub   = w_shift[WIDTH-1:0] - r_b;

  assign w_prod   = {r_acc, r_q};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -r_q : r_q;
  assign w_rem    = r_neg_r ? -r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mdu) begin
              r_state  <= S_BUSY;
              r_cnt    <= '0;
              r_is_div <= ALU_Ctr[1];
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_dz     <= (B == '0);
              r_a      <= A;
              r_acc    <= '0;
              r_b      <= ALU_Ctr[1] ? w_b_mag : w_a_mag;
              r_q      <= ALU_Ctr[1] ? w_a_mag : w_b_mag;
            end else begin
              res       <= w_res;
              zero      <= (w_res == '0);
              overflow  <= w_ovf;
              out_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (w_flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_is_div) begin
              r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], w_ge};
            end else begin
              r_acc <= w_madd[WIDTH:1];
              r_q   <= {w_madd[0], r_q[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == SHW'(WIDTH-1)) r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          if (!w_flush) begin
            if (!r_is_div) begin
              hi <= w_prod_s[2*WIDTH-1:WIDTH];
              lo <= w_prod_s[WIDTH-1:0];
            end else if (r_dz) begin
              hi <= r_a;
              lo <= '1;
            end else begin
              hi <= w_rem;
              lo <= w_quo;
            end
            res       <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed and random ops against an arithmetic reference model.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_i, b_i;
  logic [3:0]  ctr;
  logic        sgn;
  logic        out_valid;
  logic [31:0] res, hi, lo;
  logic        zero, overflow;

  logic        v16, rdy16, ov16, z16, of16;
  logic [15:0] a16, b16, r16, hi16, lo16;
  logic [3:0]  c16;
  logic        flush_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  alu_mdu u_dut (
    .clk(clk), .rst(rst),
`ifdef ALU_MDU_FLUSH_EN
    .flush(flush_i),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .A(a_i), .B(b_i), .ALU_Ctr(ctr),
    .alu_sign(sgn), .out_valid(out_valid), .res(res), .zero(zero),
    .overflow(overflow), .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
`ifdef ALU_MDU_FLUSH_EN
    .flush(1'b0),
`endif
    .in_valid(v16), .in_ready(rdy16), .A(a16), .B(b16), .ALU_Ctr(c16),
    .alu_sign(1'b0), .out_valid(ov16), .res(r16), .zero(z16),
    .overflow(of16), .hi(hi16), .lo(lo16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Reference for single-cycle ops, using 64-bit signed arithmetic.
  function automatic void ref_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic sg, output logic [31:0] r, output logic ov);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    r = 32'h0;
    ov = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010, 4'b0110: begin
        s = (op == 4'b0010) ? sa + sb : sa - sb;
        r = s[31:0];
        ov = sg && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'b0100: r = ~(a | b);
      4'b0011: r = a ^ b;
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0101: r = a >> (b % 32);
      4'b1100: r = exp_hi;
      4'b1101: r = exp_lo;
      default: r = 32'h0;
    endcase
  endfunction

  function automatic void ref_mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q, rm;
    logic [63:0] p;
    case (op)
      4'b1000: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      4'b1001: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else if (op == 4'b1010) begin
          q = sa / sb; rm = sa % sb;
          h = rm[31:0]; l = q[31:0];
        end else begin
          h = a % b; l = a / b;
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic sg);
    @(negedge clk);
    ctr = op; a_i = a; b_i = b; sgn = sg; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [31:0] er;
    logic eo;
    ref_single(op, a, b, sg, er, eo);
    issue(op, a, b, sg);
    check($sformatf("res op%b", op), res, er);
    check("zero", zero, er == 32'h0);
    check("overflow", overflow, eo);
    check("out_valid single", out_valid, 1'b1);
    check("in_ready single", in_ready, 1'b1);
  endtask

  task automatic run_mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n, busy;
    ref_mdu(op, a, b, eh, el);
    issue(op, a, b, 1'b0);
    n = 0;
    busy = in_ready ? 0 : 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!in_ready) busy++;
    end
    check($sformatf("latency op%b", op), n, 33);
    check("busy cycles", busy, 33);
    check($sformatf("hi op%b a=%h b=%h", op, a, b), hi, eh);
    check($sformatf("lo op%b a=%h b=%h", op, a, b), lo, el);
    check("fin res", res, 32'h0);
    check("fin zero", zero, 1'b1);
    check("fin overflow", overflow, 1'b0);
    exp_hi = eh;
    exp_lo = el;
    @(posedge clk);
    #1;
    check("out_valid drops", out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er;
    logic eo;
    logic [3:0] sops [12];
    int n;
    sops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0011,
             4'b0111, 4'b0101, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    rst = 1'b1; in_valid = 1'b0; a_i = '0; b_i = '0; ctr = '0; sgn = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; c16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset res", res, 32'h0);
    check("reset zero", zero, 1'b0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

    run_single(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    check("add ovf const", overflow, 1'b1);
    run_single(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0);
    run_single(4'b0110, 32'h8000_0000, 32'h1, 1'b1);

    run_mdu(4'b1000, 32'hFFFF_FFFD, 32'd5);
    check("mult -3*5 hi const", hi, 32'hFFFF_FFFF);
    run_single(4'b1101, 32'h0, 32'h0, 1'b0);
    check("mflo const", res, 32'hFFFF_FFF1);
    run_mdu(4'b1010, 32'hFFFF_FFF9, 32'd2);
    run_mdu(4'b1011, 32'd7, 32'd2);
    run_mdu(4'b1010, 32'h1234_5678, 32'h0);
    run_mdu(4'b1011, 32'h8765_4321, 32'h0);
    run_mdu(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mdu(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_single(4'b1100, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 12; i++)
      run_mdu(4'(8 + $urandom_range(0, 3)), pick(), pick());

    // Back-to-back single-cycle issue: in_valid held high across consecutive edges.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ctr = sops[$urandom_range(0, 11)];
      a_i = pick(); b_i = pick(); sgn = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      ref_single(ctr, a_i, b_i, sgn, er, eo);
      @(posedge clk);
      #1;
      check($sformatf("b2b res op%b a=%h b=%h", ctr, a_i, b_i), res, er);
      check("b2b overflow", overflow, eo);
      check("b2b out_valid", out_valid, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Reset during a multu discards the operation and clears HI/LO.
    issue(4'b1001, 32'hFFFF_FFFF, 32'h2, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst mid in_ready", in_ready, 1'b1);
    check("rst mid out_valid", out_valid, 1'b0);
    check("rst mid hi", hi, 32'h0);
    check("rst mid lo", lo, 32'h0);
    exp_hi = '0;
    exp_lo = '0;
    repeat (40) begin
      @(posedge clk);
      #1;
      check("no late out_valid", out_valid, 1'b0);
    end
    run_single(4'b1101, 32'h0, 32'h0, 1'b0);

`ifdef ALU_MDU_FLUSH_EN
    run_mdu(4'b1001, 32'd6, 32'd7);
    issue(4'b1001, 32'hFFFF_FFFF, 32'h2, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush in_ready", in_ready, 1'b1);
    check("flush out_valid", out_valid, 1'b0);
    check("flush hi", hi, exp_hi);
    check("flush lo", lo, exp_lo);
`endif

    // WIDTH=16 instance.
    @(negedge clk);
    c16 = 4'b0101; a16 = 16'h8000; b16 = 16'h000F; v16 = 1'b1;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    check("w16 srl", r16, 16'h0001);
    check("w16 srl valid", ov16, 1'b1);
    @(negedge clk);
    c16 = 4'b1001; a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w16 latency", n, 17);
    check("w16 hi", hi16, 16'hFFFE);
    check("w16 lo", lo16, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
